// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI master: state encoding,
// frame geometry and the field widths of the decoded joystick sample.
package jstk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_TRAIL = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int         NUM_BYTES     = 5;
    localparam int         BITS_PER_BYTE = 8;
    localparam logic [5:0] CMD_PREFIX    = 6'b100000;

    localparam int X_W   = 10;
    localparam int Y_W   = 10;
    localparam int BTN_W = 3;

    // First byte of every frame: fixed command prefix followed by the LED bits.
    function automatic logic [7:0] cmd_byte(input logic [1:0] led);
        return {CMD_PREFIX, led};
    endfunction

endpackage

// File: rtl/jstk_sclk_tick.sv
// Enable-gated half-period counter; tick marks the last clk of each SCLK
// half-period and the count is parked at zero whenever the enable is low.
module jstk_sclk_tick
    import jstk_pkg::*;
#(
    parameter int HALF_PERIOD = 751
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jstk_spi_ctrl.sv
// PmodJSTK SPI master: runs one 5-byte mode-0 exchange per request (start
// pulse or poll timer) and publishes X/Y/buttons atomically with done.
module jstk_spi_ctrl
    import jstk_pkg::*;
#(
    parameter int HALF_PERIOD = 751,
    parameter int SS_LEAD_HP  = 2,
    parameter int BYTE_GAP_HP = 2,
    parameter int POLL_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             auto_en,
    input  logic [1:0]       led,
    input  logic             miso,
    output logic             sclk,
    output logic             mosi,
    output logic             ss,
    output logic             busy,
    output logic             done,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [BTN_W-1:0] buttons
);

    localparam int                POLL_W     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [7:0]        LEAD_LAST  = 8'(SS_LEAD_HP - 1);
    localparam logic [7:0]        GAP_LAST   = 8'(BYTE_GAP_HP - 1);
    localparam logic [7:0]        SHIFT_LAST = 8'(2 * BITS_PER_BYTE - 1);
    localparam logic [2:0]        LAST_BYTE  = 3'(NUM_BYTES - 1);

    state_t              state;
    state_t              state_next;
    logic                active_next;
    logic                tick;
    logic                tick_en;
    logic [7:0]          phase_cnt;
    logic [2:0]          byte_idx;
    logic [POLL_W-1:0]   poll_cnt;
    logic                poll_req;
    logic                req;
    logic                launch;
    logic                pending;
    logic [7:0]          cmd;
    logic                rise_tick;
    logic                fall_tick;
    logic                byte_end;
    logic                gap_end;

    logic                miso_p0;
    logic [6:0]          tx_rest;
    logic [7:0]          rx_sh;
    logic [X_W-1:0]      x_stage;
    logic [Y_W-1:0]      y_stage;
    logic [BTN_W-1:0]    btn_stage;

    assign tick_en = state inside {ST_LEAD, ST_SHIFT, ST_GAP, ST_TRAIL};

    jstk_sclk_tick #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_sclk_tick (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .tick(tick)
    );

    assign poll_req = auto_en && (poll_cnt == POLL_LAST);
    assign req      = start || poll_req;
    // DONE accepts a request directly so a queued one costs only one low busy cycle.
    assign launch   = (state == ST_IDLE || state == ST_DONE) && (req || pending);
    assign cmd      = cmd_byte(led);

    assign rise_tick = (state == ST_SHIFT) && tick && !phase_cnt[0];
    assign fall_tick = (state == ST_SHIFT) && tick &&  phase_cnt[0];
    assign byte_end  = (state == ST_SHIFT) && tick && (phase_cnt == SHIFT_LAST);
    assign gap_end   = (state == ST_GAP)   && tick && (phase_cnt == GAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if (auto_en) begin
            poll_cnt <= poll_req ? '0 : poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (launch) begin
            pending <= 1'b0;
        end else if (req && tick_en) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        active_next = 1'b0;
        case (state)
            ST_IDLE:  if (launch) state_next = ST_LEAD;
            ST_LEAD:  if (tick && phase_cnt == LEAD_LAST) state_next = ST_SHIFT;
            ST_SHIFT: if (byte_end) state_next = (byte_idx == LAST_BYTE) ? ST_TRAIL : ST_GAP;
            ST_GAP:   if (gap_end) state_next = ST_SHIFT;
            ST_TRAIL: if (tick) state_next = ST_DONE;
            ST_DONE:  state_next = launch ? ST_LEAD : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        active_next = state_next inside {ST_LEAD, ST_SHIFT, ST_GAP, ST_TRAIL};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt <= '0;
            byte_idx  <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            ss        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            x         <= '0;
            y         <= '0;
            buttons   <= '0;
        end else begin
            ss   <= ~active_next;
            busy <= active_next;
            done <= (state_next == ST_DONE);

            if (state_next != state) begin
                phase_cnt <= '0;
            end else if (tick) begin
                phase_cnt <= phase_cnt + 1'b1;
            end

            if (launch) begin
                byte_idx <= '0;
            end else if (gap_end) begin
                byte_idx <= byte_idx + 1'b1;
            end

            if (state != ST_SHIFT) begin
                sclk <= 1'b0;
            end else if (tick) begin
                sclk <= ~phase_cnt[0];
            end

            if (launch) begin
                mosi <= cmd[7];
            end else if (gap_end || state_next == ST_DONE) begin
                mosi <= 1'b0;
            end else if (fall_tick) begin
                mosi <= tx_rest[6];
            end

            if (state == ST_TRAIL && state_next == ST_DONE) begin
                x       <= x_stage;
                y       <= y_stage;
                buttons <= btn_stage;
            end
        end
    end

    // Stage p0: registered MISO pin, then shift registers and per-byte field capture.
    always_ff @(posedge clk) begin
        miso_p0 <= miso;

        if (launch) begin
            tx_rest <= cmd[6:0];
        end else if (gap_end) begin
            tx_rest <= '0;
        end else if (fall_tick) begin
            tx_rest <= {tx_rest[5:0], 1'b0};
        end

        if (rise_tick) begin
            rx_sh <= {rx_sh[6:0], miso_p0};
        end

        if (byte_end) begin
            case (byte_idx)
                3'd0:    x_stage[7:0]  <= rx_sh;
                3'd1:    x_stage[9:8]  <= rx_sh[1:0];
                3'd2:    y_stage[7:0]  <= rx_sh;
                3'd3:    y_stage[9:8]  <= rx_sh[1:0];
                default: btn_stage     <= rx_sh[2:0];
            endcase
        end
    end

endmodule

// File: tb/tb_jstk_spi_ctrl.sv
// Self-checking bench for jstk_spi_ctrl with a behavioural PmodJSTK slave
// and a frame-level reference model of the expected timing and decoding.
module tb_jstk_spi_ctrl;

    localparam int HP   = 4;
    localparam int LEAD = 2;
    localparam int GAP  = 2;
    localparam int POLL = 500;
    localparam int NB   = 5;
    localparam int TXN  = HP * (LEAD + 16 * NB + (NB - 1) * GAP + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       auto_en;
    logic [1:0] led;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       ss;
    logic       busy;
    logic       done;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] buttons;

    int checks = 0;
    int errors = 0;

    logic [7:0] resp [NB];
    int         nfall = 0;
    int         rcnt = 0;
    int         rises_total = 0;
    logic [7:0] msh = 8'h00;
    logic [7:0] mosi_bytes [$];
    int         sclk_bad = 0;
    int         done_total = 0;

    jstk_spi_ctrl #(
        .HALF_PERIOD(HP),
        .SS_LEAD_HP (LEAD),
        .BYTE_GAP_HP(GAP),
        .POLL_CYCLES(POLL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .auto_en(auto_en),
        .led    (led),
        .miso   (miso),
        .sclk   (sclk),
        .mosi   (mosi),
        .ss     (ss),
        .busy   (busy),
        .done   (done),
        .x      (x),
        .y      (y),
        .buttons(buttons)
    );

    always #5 clk = ~clk;

    // Joystick slave: presents bit k of the response stream after k falling SCLK edges.
    always @(negedge sclk or posedge ss) begin
        if (ss) nfall <= 0;
        else    nfall <= nfall + 1;
    end

    always_comb begin
        miso = 1'b0;
        if (ss === 1'b0 && nfall < 8 * NB)
            miso = resp[nfall / 8][7 - (nfall % 8)];
    end

    always @(posedge sclk or posedge ss) begin
        if (ss) begin
            rcnt <= 0;
        end else begin
            msh         <= {msh[6:0], mosi};
            rcnt        <= rcnt + 1;
            rises_total <= rises_total + 1;
            if (rcnt % 8 == 7) mosi_bytes.push_back({msh[6:0], mosi});
        end
    end

    always @(negedge clk) begin
        if (ss === 1'b1 && sclk !== 1'b0) sclk_bad <= sclk_bad + 1;
        if (done === 1'b1) done_total <= done_total + 1;
    end

    function automatic int exp_x();
        return (int'(resp[1]) % 4) * 256 + int'(resp[0]);
    endfunction

    function automatic int exp_y();
        return (int'(resp[3]) % 4) * 256 + int'(resp[2]);
    endfunction

    function automatic int exp_btn();
        return int'(resp[4]) % 8;
    endfunction

    task automatic randomize_resp();
        for (int k = 0; k < NB; k++) resp[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic launch_and_wait(input logic [1:0] l, output int lat);
        @(negedge clk);
        led   = l;
        start = 1'b1;
        lat   = -1;
        for (int n = 1; n <= 4 * TXN; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sclk !== 1'b0)  begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (mosi !== 1'b0)  begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        checks++; if (ss !== 1'b1)    begin errors++; $display("FAIL reset_ss: got %b expected 1", ss); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (x !== 10'd0)    begin errors++; $display("FAIL reset_x: got %h expected 0", x); end
        checks++; if (y !== 10'd0)    begin errors++; $display("FAIL reset_y: got %h expected 0", y); end
        checks++; if (buttons !== 3'd0) begin errors++; $display("FAIL reset_buttons: got %b expected 0", buttons); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0 || ss !== 1'b1) begin
            errors++; $display("FAIL idle_no_request: busy=%b ss=%b expected busy=0 ss=1", busy, ss);
        end
    endtask

    task automatic test_default();
        int lat;
        resp[0] = 8'hA5; resp[1] = 8'h02; resp[2] = 8'h3C; resp[3] = 8'h01; resp[4] = 8'h05;
        launch_and_wait(2'($urandom_range(0, 3)), lat);
        checks++; if (lat !== TXN + 1) begin errors++; $display("FAIL default_latency: got %0d expected %0d", lat, TXN + 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL default_busy_at_done: got %b expected 0", busy); end
        checks++; if (int'(x) !== exp_x()) begin errors++; $display("FAIL default_x: got %h expected %h", x, exp_x()); end
        checks++; if (int'(y) !== exp_y()) begin errors++; $display("FAIL default_y: got %h expected %h", y, exp_y()); end
        checks++; if (int'(buttons) !== exp_btn()) begin errors++; $display("FAIL default_buttons: got %b expected %0d", buttons, exp_btn()); end
    endtask

    task automatic test_mosi();
        int q0, r0, b0, first_rise, lat, exp_b;
        randomize_resp();
        q0 = mosi_bytes.size();
        r0 = rises_total;
        b0 = sclk_bad;
        first_rise = -1;
        lat = -1;
        @(negedge clk);
        led   = 2'b10;
        start = 1'b1;
        for (int n = 1; n <= 4 * TXN; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (sclk === 1'b1 && first_rise < 0) first_rise = n;
            if (done === 1'b1) begin lat = n; break; end
        end
        checks++; if (lat !== TXN + 1) begin errors++; $display("FAIL mosi_latency: got %0d expected %0d", lat, TXN + 1); end
        checks++; if (first_rise !== 1 + (LEAD + 1) * HP) begin
            errors++; $display("FAIL first_sclk_rise: got cycle %0d expected %0d", first_rise, 1 + (LEAD + 1) * HP);
        end
        checks++; if (rises_total - r0 !== 8 * NB) begin
            errors++; $display("FAIL sclk_rise_count: got %0d expected %0d", rises_total - r0, 8 * NB);
        end
        checks++; if (sclk_bad !== b0) begin errors++; $display("FAIL sclk_outside_frame: got %0d expected %0d", sclk_bad - b0, 0); end
        checks++; if (mosi_bytes.size() - q0 !== NB) begin
            errors++; $display("FAIL mosi_byte_count: got %0d expected %0d", mosi_bytes.size() - q0, NB);
        end
        for (int k = 0; k < NB; k++) begin
            exp_b = (k == 0) ? 128 + 2 : 0;
            checks++; if (int'(mosi_bytes[q0 + k]) !== exp_b) begin
                errors++; $display("FAIL mosi_byte%0d: got %h expected %h", k, mosi_bytes[q0 + k], exp_b);
            end
        end
        checks++; if (int'(x) !== exp_x() || int'(y) !== exp_y()) begin
            errors++; $display("FAIL mosi_xy: got %h/%h expected %h/%h", x, y, exp_x(), exp_y());
        end
    endtask

    task automatic test_random();
        int lat, q0;
        logic [1:0] l;
        for (int it = 0; it < 4; it++) begin
            randomize_resp();
            l  = 2'($urandom_range(0, 3));
            q0 = mosi_bytes.size();
            launch_and_wait(l, lat);
            checks++; if (lat !== TXN + 1) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, TXN + 1); end
            checks++; if (int'(x) !== exp_x()) begin errors++; $display("FAIL rand%0d_x: got %h expected %h", it, x, exp_x()); end
            checks++; if (int'(y) !== exp_y()) begin errors++; $display("FAIL rand%0d_y: got %h expected %h", it, y, exp_y()); end
            checks++; if (int'(buttons) !== exp_btn()) begin errors++; $display("FAIL rand%0d_buttons: got %b expected %0d", it, buttons, exp_btn()); end
            checks++; if (int'(mosi_bytes[q0]) !== 128 + int'(l)) begin
                errors++; $display("FAIL rand%0d_cmd: got %h expected %h", it, mosi_bytes[q0], 128 + int'(l));
            end
        end
    endtask

    task automatic test_masking();
        int lat;
        for (int k = 0; k < NB; k++) resp[k] = 8'hFF;
        launch_and_wait(2'b01, lat);
        checks++; if (lat !== TXN + 1) begin errors++; $display("FAIL mask_latency: got %0d expected %0d", lat, TXN + 1); end
        checks++; if (int'(x) !== exp_x()) begin errors++; $display("FAIL mask_x: got %h expected %h", x, exp_x()); end
        checks++; if (int'(y) !== exp_y()) begin errors++; $display("FAIL mask_y: got %h expected %h", y, exp_y()); end
        checks++; if (int'(buttons) !== exp_btn()) begin errors++; $display("FAIL mask_buttons: got %b expected %0d", buttons, exp_btn()); end
    endtask

    task automatic test_back_to_back();
        int busy_mis, low_between, d0, d1, ncyc;
        int done_cycles [$];
        logic exp_busy;
        randomize_resp();
        busy_mis = 0;
        low_between = 0;
        ncyc = 2 * (TXN + 1) + 300;
        @(negedge clk);
        led   = 2'b11;
        start = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            start = (n == 50 || n == 100);
            exp_busy = (n >= 1 && n <= TXN) || (n >= TXN + 2 && n <= 2 * TXN + 1);
            if (busy !== exp_busy) busy_mis++;
            if (done === 1'b1) done_cycles.push_back(n);
            if (done_cycles.size() == 1 && busy === 1'b0) low_between++;
        end
        start = 1'b0;
        d0 = (done_cycles.size() > 0) ? done_cycles[0] : -1;
        d1 = (done_cycles.size() > 1) ? done_cycles[1] : -1;
        checks++; if (busy_mis !== 0) begin errors++; $display("FAIL b2b_busy_trace: got %0d wrong cycles expected 0", busy_mis); end
        checks++; if (done_cycles.size() !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cycles.size()); end
        checks++; if (d0 !== TXN + 1) begin errors++; $display("FAIL b2b_first_done: got %0d expected %0d", d0, TXN + 1); end
        checks++; if (d1 !== 2 * TXN + 2) begin errors++; $display("FAIL b2b_second_done: got %0d expected %0d", d1, 2 * TXN + 2); end
        checks++; if (low_between !== 1) begin errors++; $display("FAIL b2b_busy_gap: got %0d expected 1", low_between); end
        checks++; if (int'(x) !== exp_x() || int'(y) !== exp_y()) begin
            errors++; $display("FAIL b2b_xy: got %h/%h expected %h/%h", x, y, exp_x(), exp_y());
        end
    endtask

    task automatic test_reset_mid();
        int d0, lat;
        randomize_resp();
        @(negedge clk);
        led   = 2'b00;
        start = 1'b1;
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        d0  = done_total;
        rst = 1'b1;
        #1;
        checks++; if (ss !== 1'b1)   begin errors++; $display("FAIL midreset_ss: got %b expected 1", ss); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL midreset_sclk: got %b expected 0", sclk); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (x !== 10'd0 || y !== 10'd0 || buttons !== 3'd0) begin
            errors++; $display("FAIL midreset_xy: got %h/%h/%b expected 0/0/0", x, y, buttons);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (done_total !== d0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", done_total - d0); end
        randomize_resp();
        launch_and_wait(2'b01, lat);
        checks++; if (lat !== TXN + 1) begin errors++; $display("FAIL postreset_latency: got %0d expected %0d", lat, TXN + 1); end
        checks++; if (int'(x) !== exp_x() || int'(y) !== exp_y() || int'(buttons) !== exp_btn()) begin
            errors++; $display("FAIL postreset_data: got %h/%h/%b expected %h/%h/%0d", x, y, buttons, exp_x(), exp_y(), exp_btn());
        end
    endtask

    task automatic test_auto_poll();
        int rises [$];
        int d0, ncyc;
        logic prev;
        randomize_resp();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d0 = done_total;
        prev = 1'b0;
        ncyc = 3 * POLL + TXN + 50;
        auto_en = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (busy === 1'b1 && !prev) rises.push_back(n);
            prev = busy;
        end
        auto_en = 1'b0;
        checks++; if (rises.size() !== 3) begin errors++; $display("FAIL poll_count: got %0d starts expected 3", rises.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (((rises.size() > k) ? rises[k] : -1) !== (k + 1) * POLL) begin
                errors++; $display("FAIL poll_start%0d: got %0d expected %0d", k, (rises.size() > k) ? rises[k] : -1, (k + 1) * POLL);
            end
        end
        checks++; if (done_total - d0 !== 3) begin errors++; $display("FAIL poll_done_count: got %0d expected 3", done_total - d0); end
        checks++; if (int'(x) !== exp_x()) begin errors++; $display("FAIL poll_x: got %h expected %h", x, exp_x()); end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        auto_en = 1'b0;
        led     = 2'b00;
        for (int k = 0; k < NB; k++) resp[k] = 8'h00;
        test_reset();
        test_default();
        test_mosi();
        test_random();
        test_masking();
        test_back_to_back();
        test_reset_mid();
        test_auto_poll();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
